dmem_lsu: RTL and testbench

Load/store unit that initiates every access to the word-wide data memory on behalf of the pipeline MEM stage. It accepts byte-addressed byte, halfword and word requests over a valid/ready handshake and drives the memory's en/we/addr/wdata port. It consumes the memory's one-cycle read latency and returns sign- or zero-extended load data. Subword stores are done as read-modify-write, because the memory has no byte enables.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_lane_align.sv | 35 +++
 rtl/dmem_lsu.sv | 144 ++++++++++++++
 tb/tb_dmem_lsu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM
// states and byte-lane helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_MERGE = 2'd2,
    RESP      = 2'd3
  } lsu_state_e;

  // Size 11 is an alias of a full word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic [4:0] byte_lsb(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

  function automatic logic [4:0] half_lsb(input logic [1:0] off);
    return {off[1], 4'b0000};
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (is_word(size) && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and subword store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [15:0] store_data,
  output logic [31:0] load_result,
  output logic [31:0] store_merged
);

  logic [31:0] byte_lane;
  logic [31:0] half_lane;

  always_comb begin
    byte_lane = mem_word >> byte_lsb(offset);
    half_lane = mem_word >> half_lsb(offset);
    load_result = mem_word;
    store_merged = mem_word;
    case (size)
      SZ_BYTE: begin
        load_result = {{24{is_signed & byte_lane[7]}}, byte_lane[7:0]};
        store_merged[byte_lsb(offset) +: BYTE_W] = store_data[7:0];
      end
      SZ_HALF: begin
        load_result = {{16{is_signed & half_lane[15]}}, half_lane[15:0]};
        store_merged[half_lsb(offset) +: HALF_W] = store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-wide, byte-enable-less data memory.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halves/words with resp_err.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e state, state_next;

  logic              accept;
  logic              req_mis;
  logic [ADDR_W-1:0] req_waddr;
  logic              unused_addr_hi;

  logic [1:0]        cap_size;
  logic              cap_signed;
  logic [1:0]        cap_off;
  logic [ADDR_W-1:0] cap_waddr;
  logic [15:0]       cap_wdata;

  logic [31:0]       load_result;
  logic [31:0]       store_merged;

  assign req_waddr      = req_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign accept         = req_valid && req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = is_misaligned(req_size, req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mis)                           state_next = RESP;
          else if (req_we && is_word(req_size))  state_next = RESP;
          else if (req_we)                       state_next = RMW_MERGE;
          else                                   state_next = LOAD_WAIT;
        end
      end
      LOAD_WAIT: state_next = RESP;
      RMW_MERGE: state_next = RESP;
      default:   state_next = IDLE;
    endcase
  end

  // Accept cycle steers the memory straight from the request; later states use captured fields.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == RESP);
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cap_waddr;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        mem_addr = req_waddr;
        if (accept && !req_mis) begin
          if (req_we && is_word(req_size)) begin
            mem_we    = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_en = 1'b1;
          end
        end
      end
      RMW_MERGE: begin
        mem_we    = 1'b1;
        mem_wdata = store_merged;
      end
      default: ;
    endcase
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_size   <= req_size;
      cap_signed <= req_signed;
      cap_off    <= req_addr[1:0];
      cap_waddr  <= req_waddr;
      cap_wdata  <= req_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     resp_rdata <= '0;
    else if (accept)             resp_rdata <= '0;
    else if (state == LOAD_WAIT) resp_rdata <= load_result;
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic resp_err_q;
  always_ff @(posedge clk) begin
    if (rst)         resp_err_q <= 1'b0;
    else if (accept) resp_err_q <= req_mis;
  end
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  lsu_lane_align u_align (
    .size         (cap_size),
    .is_signed    (cap_signed),
    .offset       (cap_off),
    .mem_word     (mem_rdata),
    .store_data   (cap_wdata),
    .load_result  (load_result),
    .store_merged (store_merged)
  );

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a one-cycle-latency word memory model.
module tb_dmem_lsu;
  import lsu_pkg::*;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // One complete request: accept-cycle memory port, response cycle and return to idle.
  task automatic runOp(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic en_t, input logic we_t, input int lat,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
    logic [ADDR_W-1:0] exp_waddr;
    exp_waddr = addr[ADDR_W+1:2];
    @(negedge clk);
    applyStimulus(we, size, sgn, addr, wdata);
    #1;
    checkOutput({tag, ".ready_T"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, ".en_T"}, {31'd0, mem_en}, {31'd0, en_t});
    checkOutput({tag, ".we_T"}, {31'd0, mem_we}, {31'd0, we_t});
    if (en_t || we_t) checkOutput({tag, ".addr_T"}, {18'd0, mem_addr}, {18'd0, exp_waddr});
    if (we_t) checkOutput({tag, ".wdata_T"}, mem_wdata, exp_wdata);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      checkOutput({tag, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, (k == lat)});
      checkOutput({tag, ".ready_busy"}, {31'd0, req_ready}, 32'd0);
      if (k < lat && we) begin
        checkOutput({tag, ".rmw_we"}, {31'd0, mem_we}, 32'd1);
        checkOutput({tag, ".rmw_wdata"}, mem_wdata, exp_wdata);
      end
      if (k == lat) begin
        checkOutput({tag, ".rdata"}, resp_rdata, exp_rdata);
        checkOutput({tag, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
        checkOutput({tag, ".mem_idle_resp"}, {30'd0, mem_en, mem_we}, 32'd0);
      end
    end
    @(negedge clk);
    #1;
    checkOutput({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, ".resp_after"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = SZ_WORD;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst.rdata", resp_rdata, 32'd0);
    checkOutput("rst.err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst.mem", {30'd0, mem_en, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst.ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] word store / word load");
    runOp("st_w", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1, 32'hDEADBEEF, 32'h0, 1'b0);
    checkOutput("st_w.mem4", mem[4], 32'hDEADBEEF);
    runOp("ld_w", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'hDEADBEEF, 1'b0);
    runOp("ld_sz3", 1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] subword stores and loads");
    runOp("st_w2", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 1'b0, 1'b1, 1, 32'h11223344, 32'h0, 1'b0);
    runOp("st_b13", 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h12345680, 1'b1, 1'b0, 2, 32'h80223344, 32'h0, 1'b0);
    checkOutput("st_b13.mem4", mem[4], 32'h80223344);
    runOp("ld_sb13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'hFFFFFF80, 1'b0);
    runOp("ld_ub13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h00000080, 1'b0);
    runOp("ld_sh12", 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'hFFFF8022, 1'b0);
    runOp("ld_uh12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h00008022, 1'b0);
    runOp("ld_ub10", 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h00000044, 1'b0);
    runOp("ld_sb11", 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h00000033, 1'b0);
    runOp("st_h10", 1'b1, SZ_HALF, 1'b0, 32'h10, 32'h9999ABCD, 1'b1, 1'b0, 2, 32'h8022ABCD, 32'h0, 1'b0);
    checkOutput("st_h10.mem4", mem[4], 32'h8022ABCD);
    runOp("ld_sh10", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'hFFFFABCD, 1'b0);

    $display("[TB] back-to-back loads with req_valid held");
    @(negedge clk);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 9; c++) begin
      if (c == 7) req_valid = 1'b0;
      #1;
      checkOutput($sformatf("held.accept_c%0d", c), {31'd0, req_valid && req_ready},
                  {31'd0, (c % 3 == 0) && (c <= 6)});
      checkOutput($sformatf("held.en_c%0d", c), {31'd0, mem_en}, {31'd0, (c % 3 == 0) && (c <= 6)});
      checkOutput($sformatf("held.resp_c%0d", c), {31'd0, resp_valid}, {31'd0, (c % 3 == 2)});
      @(negedge clk);
    end
    #1;
    checkOutput("held.idle_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("held.last_rdata", resp_rdata, 32'h8022ABCD);

    $display("[TB] reset during read-modify-write");
    @(negedge clk);
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'h10, 32'h00000055);
    #1;
    checkOutput("rmw_rst.en_T", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rmw_rst.we_forced", {31'd0, mem_we}, 32'd0);
    checkOutput("rmw_rst.en_forced", {31'd0, mem_en}, 32'd0);
    checkOutput("rmw_rst.ready_in_rst", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rmw_rst.no_resp", {31'd0, resp_valid}, 32'd0);
    checkOutput("rmw_rst.ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rmw_rst.rdata_clr", resp_rdata, 32'd0);
    checkOutput("rmw_rst.mem4", mem[4], 32'h8022ABCD);
    @(negedge clk);
    #1;
    checkOutput("rmw_rst.no_resp2", {31'd0, resp_valid}, 32'd0);

    $display("[TB] misaligned word load");
`ifdef DMEM_ALIGN_CHECK_EN
    runOp("ld_w11", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 1'b0, 1'b0, 1, 32'h0, 32'h0, 1'b1);
    runOp("ld_h13", 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0, 1, 32'h0, 32'h0, 1'b1);
`else
    runOp("ld_w11", 1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h8022ABCD, 1'b0);
    runOp("ld_h13", 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0, 2, 32'h0, 32'h00008022, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
